expression_builder: RTL and testbench

Sits directly downstream of the keyboard decoder and turns its per-key level strobes into a complete two-operand calculator request. Edge-detects each strobe so a held key counts once, and accumulates BCD digits into operand A. Latches the operator, then accumulates operand B. On submit, presents {A, operator, B} to the link/transmit stage over a valid/ready handshake, and drives the entry display meanwhile.

---
 rtl/expression_builder.sv | 154 +++++++++++++++
 tb/tb_expression_builder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/expression_builder.sv
// expression_builder: turns key-level strobes from the keyboard decoder into a
// two-operand BCD calculator request {A, operator, B} delivered over a
// valid/ready handshake, and drives the entry display while keys are typed.
module expression_builder #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            num,
   input  logic                  numPressed,
   input  logic [1:0]            opt,
   input  logic                  optPressed,
   input  logic                  clear,
   input  logic                  submit,
   output logic [4*DIGITS-1:0]   display,
   output logic                  full,
   output logic                  busy,
   output logic                  reqValid,
   input  logic                  reqReady,
   output logic [4*DIGITS-1:0]   reqA,
   output logic [4*DIGITS-1:0]   reqB,
   output logic [1:0]            reqOpt
);

   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);

   typedef enum logic [1:0] {
      ENTRY_A,
      ENTRY_B,
      SEND
   } state_t;

   state_t        state;
   logic          num_q, opt_q, clear_q, submit_q;
   logic [W-1:0]  a_val, b_val;
   logic [CW-1:0] a_cnt, b_cnt;
   logic [1:0]    opt_reg;

   // Rising-edge events: a held key produces exactly one event.
   logic num_ev, opt_ev, clear_ev, submit_ev;
   assign num_ev    = numPressed & ~num_q;
   assign opt_ev    = optPressed & ~opt_q;
   assign clear_ev  = clear      & ~clear_q;
   assign submit_ev = submit     & ~submit_q;

   // A digit is accepted only if it is a real BCD code, there is room left,
   // and it is not a leading zero.
   logic digit_ok, a_take, b_take;
   assign digit_ok = (num <= 4'd9);
   assign a_take   = (a_cnt < MAX_CNT) && !((a_cnt == '0) && (num == 4'd0));
   assign b_take   = (b_cnt < MAX_CNT) && !((b_cnt == '0) && (num == 4'd0));

   // Entry is wiped either by a clear key while typing or by a completed
   // handshake; clear has no effect while a request is pending.
   logic wipe;
   assign wipe = (state == SEND) ? reqReady : clear_ev;

   assign busy     = (state == SEND);
   assign reqValid = (state == SEND);

   // Edge-detect registers, operand accumulation, operator latch and request capture.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: every register, including the request payload, is cleared by the
      // asynchronous reset so reqValid and the payload drop the moment reset asserts.
      if (!reset) begin
         state    <= ENTRY_A;
         num_q    <= 1'b0;
         opt_q    <= 1'b0;
         clear_q  <= 1'b0;
         submit_q <= 1'b0;
         a_val    <= '0;
         b_val    <= '0;
         a_cnt    <= '0;
         b_cnt    <= '0;
         opt_reg  <= 2'd0;
         reqA     <= '0;
         reqB     <= '0;
         reqOpt   <= 2'd0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, so the event decode above sees the old *_q copies.
         num_q    <= numPressed;
         opt_q    <= optPressed;
         clear_q  <= clear;
         submit_q <= submit;

         if (wipe) begin
            state   <= ENTRY_A;
            a_val   <= '0;
            b_val   <= '0;
            a_cnt   <= '0;
            b_cnt   <= '0;
            opt_reg <= 2'd0;
         end else if (state != SEND) begin
            // Priority clear > submit > opt > num; only the winner is acted on.
            if (submit_ev) begin
               if ((state == ENTRY_B) && (b_cnt != '0)) begin
                  reqA   <= a_val;
                  reqB   <= b_val;
                  reqOpt <= opt_reg;
                  state  <= SEND;
               end
            end else if (opt_ev) begin
               if (opt != 2'd0) begin
                  if (state == ENTRY_A) begin
                     opt_reg <= opt;
                     state   <= ENTRY_B;
                  end else if (b_cnt == '0) begin
                     opt_reg <= opt;
                  end
               end
            end else if (num_ev && digit_ok) begin
               if (state == ENTRY_A) begin
                  if (a_take) begin
                     a_val <= {a_val[W-5:0], num};
                     a_cnt <= a_cnt + CW'(1);
                  end
               end else if (b_take) begin
                  b_val <= {b_val[W-5:0], num};
                  b_cnt <= b_cnt + CW'(1);
               end
            end
         end
      end
   end

   // Display and full flag follow the operand currently being shown.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves an output unassigned.
      display = a_val;
      full    = 1'b0;
      unique case (state)
         ENTRY_A: begin
            display = a_val;
            full    = (a_cnt == MAX_CNT);
         end
         ENTRY_B: begin
            display = (b_cnt != '0) ? b_val : a_val;
            full    = (b_cnt == MAX_CNT);
         end
         SEND: begin
            display = b_val;
            full    = 1'b0;
         end
         default: begin
            display = a_val;
            full    = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_expression_builder.sv
// Testbench for expression_builder: directed scenarios plus randomized key
// presses, checked every cycle against a decimal-arithmetic reference model.
module tb_expression_builder;

   localparam int DIGITS = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  num = 4'd0;
   logic        numPressed = 1'b0;
   logic [1:0]  opt = 2'd0;
   logic        optPressed = 1'b0;
   logic        clear = 1'b0;
   logic        submit = 1'b0;
   logic        reqReady = 1'b0;
   logic [15:0] display, reqA, reqB;
   logic        full, busy, reqValid;
   logic [1:0]  reqOpt;

   expression_builder #(.DIGITS(DIGITS)) dut (
      .clk        (clk),
      .reset      (reset),
      .num        (num),
      .numPressed (numPressed),
      .opt        (opt),
      .optPressed (optPressed),
      .clear      (clear),
      .submit     (submit),
      .display    (display),
      .full       (full),
      .busy       (busy),
      .reqValid   (reqValid),
      .reqReady   (reqReady),
      .reqA       (reqA),
      .reqB       (reqB),
      .reqOpt     (reqOpt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: operands kept as plain decimal integers.
   typedef enum {M_A, M_B, M_SEND} mode_t;
   mode_t m_mode;
   int    m_a, m_b, m_an, m_bn, m_op, m_ra, m_rb, m_ro;
   bit    p_n, p_o, p_c, p_s;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r = '0;
      int x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_mode = M_A;
      m_a = 0; m_b = 0; m_an = 0; m_bn = 0; m_op = 0;
      m_ra = 0; m_rb = 0; m_ro = 0;
      p_n = 0; p_o = 0; p_c = 0; p_s = 0;
   endtask

   task automatic model_wipe();
      m_mode = M_A;
      m_a = 0; m_b = 0; m_an = 0; m_bn = 0; m_op = 0;
   endtask

   task automatic model_step();
      bit en, eo, ec, es;
      int d;
      en = numPressed && !p_n;
      eo = optPressed && !p_o;
      ec = clear && !p_c;
      es = submit && !p_s;
      d  = int'(num);
      if (m_mode == M_SEND) begin
         if (reqReady) model_wipe();
      end else if (ec) begin
         model_wipe();
      end else if (es) begin
         if (m_mode == M_B && m_bn > 0) begin
            m_ra = m_a; m_rb = m_b; m_ro = m_op; m_mode = M_SEND;
         end
      end else if (eo) begin
         if (opt != 0) begin
            if (m_mode == M_A) begin
               m_op = int'(opt); m_mode = M_B;
            end else if (m_bn == 0) begin
               m_op = int'(opt);
            end
         end
      end else if (en && d <= 9) begin
         if (m_mode == M_A) begin
            if (m_an < DIGITS && !(m_an == 0 && d == 0)) begin m_a = m_a * 10 + d; m_an++; end
         end else begin
            if (m_bn < DIGITS && !(m_bn == 0 && d == 0)) begin m_b = m_b * 10 + d; m_bn++; end
         end
      end
      p_n = numPressed; p_o = optPressed; p_c = clear; p_s = submit;
   endtask

   always @(posedge clk) begin
      if (!reset) model_reset();
      else model_step();
   end

   // Every-cycle comparison of all outputs against the model.
   bit mon_en = 0;
   always @(negedge clk) begin
      if (mon_en) begin
         int shown;
         bit exp_full;
         case (m_mode)
            M_A:     begin shown = m_a; exp_full = (m_an == DIGITS); end
            M_B:     begin shown = (m_bn > 0) ? m_b : m_a; exp_full = (m_bn == DIGITS); end
            default: begin shown = m_b; exp_full = 0; end
         endcase
         check("mon_display", 32'(display), 32'(to_bcd(shown)));
         check("mon_full", 32'(full), 32'(exp_full));
         check("mon_busy", 32'(busy), 32'(m_mode == M_SEND));
         check("mon_reqValid", 32'(reqValid), 32'(m_mode == M_SEND));
         check("mon_reqA", 32'(reqA), 32'(to_bcd(m_ra)));
         check("mon_reqB", 32'(reqB), 32'(to_bcd(m_rb)));
         check("mon_reqOpt", 32'(reqOpt), 32'(m_ro));
      end
   end

   bit rand_ready = 0;

   task automatic cycle();
      @(negedge clk);
      if (rand_ready) reqReady = 1'($urandom_range(0, 1));
   endtask

   // kind: 0 digit, 1 operator, 2 clear, 3 submit
   task automatic press(input int kind, input int val, input int hold, input int gap);
      case (kind)
         0: begin num = 4'(val); numPressed = 1'b1; end
         1: begin opt = 2'(val); optPressed = 1'b1; end
         2: clear = 1'b1;
         default: submit = 1'b1;
      endcase
      repeat (hold) cycle();
      numPressed = 1'b0; optPressed = 1'b0; clear = 1'b0; submit = 1'b0;
      repeat (gap) cycle();
   endtask

   task automatic digits(input int v);
      int q[$];
      int x = v;
      while (x > 0) begin q.push_front(x % 10); x = x / 10; end
      foreach (q[i]) press(0, q[i], 2, 1);
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_display", 32'(display), 32'h0);
      check("rst_full", 32'(full), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_reqValid", 32'(reqValid), 32'h0);
      check("rst_reqA", 32'(reqA), 32'h0);
      check("rst_reqB", 32'(reqB), 32'h0);
      check("rst_reqOpt", 32'(reqOpt), 32'h0);
      reset = 1'b1;
      mon_en = 1;
      cycle();

      // Digits 1,2,3 held 5 cycles each.
      press(0, 1, 5, 1); press(0, 2, 5, 1); press(0, 3, 5, 1);
      check("abc_display", 32'(display), 32'h0123);
      check("abc_full", 32'(full), 32'h0);

      // Leading zeros ignored, fifth digit dropped.
      press(2, 0, 1, 1);
      press(0, 0, 2, 1); press(0, 0, 2, 1);
      digits(98765);
      check("lim_display", 32'(display), 32'h9876);
      check("lim_full", 32'(full), 32'h1);

      // A=12, opt 1 then 2, B=34, submit with reqReady low, clear in SEND ignored.
      press(2, 0, 1, 1);
      digits(12); press(1, 1, 2, 1); press(1, 2, 2, 1); digits(34);
      press(3, 0, 2, 1);
      check("req_valid", 32'(reqValid), 32'h1);
      check("req_A", 32'(reqA), 32'h0012);
      check("req_B", 32'(reqB), 32'h0034);
      check("req_opt", 32'(reqOpt), 32'h2);
      press(2, 0, 1, 1);
      check("send_clear_busy", 32'(busy), 32'h1);
      reqReady = 1'b1;
      cycle();
      reqReady = 1'b0;
      check("hs_valid", 32'(reqValid), 32'h0);
      check("hs_display", 32'(display), 32'h0);

      // Submit in ENTRY_A and in ENTRY_B with empty B: no request.
      press(3, 0, 2, 1);
      check("subA_valid", 32'(reqValid), 32'h0);
      press(0, 5, 2, 1); press(1, 1, 2, 1); press(3, 0, 2, 1);
      check("subB_valid", 32'(reqValid), 32'h0);
      check("subB_display", 32'(display), 32'h0005);
      press(2, 0, 1, 1);
      check("clrB_display", 32'(display), 32'h0);

      // Submit and clear rise together in ENTRY_B: clear wins.
      digits(3); press(1, 1, 2, 1); digits(4);
      submit = 1'b1; clear = 1'b1;
      cycle();
      submit = 1'b0; clear = 1'b0;
      cycle();
      check("race_valid", 32'(reqValid), 32'h0);
      check("race_display", 32'(display), 32'h0);

      // Digit held 20 cycles enters once.
      press(0, 7, 20, 1);
      check("hold_display", 32'(display), 32'h0007);

      // Reset mid-SEND drops reqValid asynchronously.
      press(2, 0, 1, 1);
      digits(1); press(1, 1, 2, 1); digits(2); press(3, 0, 1, 1);
      check("pre_rst_valid", 32'(reqValid), 32'h1);
      #2 reset = 1'b0;
      model_reset();
      #1;
      check("async_rst_valid", 32'(reqValid), 32'h0);
      check("async_rst_reqA", 32'(reqA), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      cycle();

      // A=5 + B=7 with reqReady already high: SEND lasts one cycle.
      reqReady = 1'b1;
      digits(5); press(1, 1, 2, 1); digits(7);
      submit = 1'b1;
      cycle();
      check("fast_valid", 32'(reqValid), 32'h1);
      check("fast_A", 32'(reqA), 32'h0005);
      check("fast_B", 32'(reqB), 32'h0007);
      check("fast_opt", 32'(reqOpt), 32'h1);
      cycle();
      check("fast_valid_drop", 32'(reqValid), 32'h0);
      submit = 1'b0;
      reqReady = 1'b0;
      cycle();

      // Randomized key presses with random downstream readiness.
      rand_ready = 1;
      for (int i = 0; i < 400; i++) begin
         int r, kind, val;
         r = int'($urandom_range(0, 99));
         kind = (r < 55) ? 0 : (r < 72) ? 1 : (r < 77) ? 2 : 3;
         val  = (kind == 0) ? int'($urandom_range(0, 11)) : int'($urandom_range(0, 3));
         press(kind, val, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
      end
      rand_ready = 0;
      reqReady = 1'b0;
      repeat (3) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
